// File: rtl/gpu_pkg.sv
// Shared types for the warp scheduler: core phase and per-warp status encodings.
// Latency: n/a (type definitions only).
// Backpressure: n/a.
//
// Contents: core_state_e (scheduler phase, driven out on core_state),
//           warp_state_e (per-warp status held inside the scheduler).
package gpu_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SELECT  = 3'd1,
      S_FETCH   = 3'd2,
      S_DECODE  = 3'd3,
      S_EXECUTE = 3'd4,
      S_UPDATE  = 3'd5,
      S_DONE    = 3'd6
   } core_state_e;

   typedef enum logic [1:0] {
      W_IDLE     = 2'd0,
      W_READY    = 2'd1,
      W_WAIT_MEM = 2'd2,
      W_DONE     = 2'd3
   } warp_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first requester strictly after the last grant, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; grant_valid low when no request bit is set.
//
// Ports: i_req         request mask, one bit per requester
//        i_last        index granted last time (search starts one past it)
//        o_grant_valid at least one request present
//        o_grant_idx   chosen requester (0 when none)
module rr_arbiter #(
   parameter int N = 4,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_last,
   output logic          o_grant_valid,
   output logic [IW-1:0] o_grant_idx
);

   logic [IW-1:0] w_cand;

   // N is a power of two, so IW-bit addition wraps the search naturally;
   // k == N lands back on i_last, which is therefore checked last.
   always_comb begin
      o_grant_valid = 1'b0;
      o_grant_idx   = '0;
      w_cand        = '0;
      for (int k = 1; k <= N; k++) begin
         w_cand = i_last + IW'(k);
         if (!o_grant_valid && i_req[w_cand]) begin
            o_grant_valid = 1'b1;
            o_grant_idx   = w_cand;
         end
      end
   end

endmodule

// File: rtl/warp_scheduler.sv
// Multi-warp scheduler: round-robin warp pick, drives fetch/decode/execute/update, parks warps on memory ops.
// Latency: best case one ALU issue per 5 cycles (SELECT, FETCH, DECODE, EXECUTE, UPDATE).
// Backpressure: fetch_valid/fetch_pc held until fetch_ready; SELECT idles while every live warp waits on memory.
//
// Ports: i_clk, i_reset (sync, active low); i_start / i_warp_count launch a kernel from S_IDLE;
//        o_fetch_valid / o_fetch_pc / i_fetch_ready fetch handshake; i_decoded_mem / i_decoded_ret decode result;
//        o_cur_warp, o_core_state selected warp and phase; o_issue_valid execute strobe; o_lsu_req memory strobe;
//        i_lsu_done_valid / i_lsu_done_warp memory completion; i_next_pc written back in S_UPDATE; o_done all retired.
// Build option: define WARP_SCHED_PERF_EN to add o_perf_issued and o_perf_stall counters.
module warp_scheduler
   import gpu_pkg::*;
#(
   parameter int NUM_WARPS        = 4,
   parameter int THREADS_PER_WARP = 4,
   parameter int PC_BITS          = 8,
   localparam int WARP_IDX_W      = $clog2(NUM_WARPS)
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_start,
   input  logic [WARP_IDX_W:0]   i_warp_count,
   output logic                  o_fetch_valid,
   output logic [PC_BITS-1:0]    o_fetch_pc,
   input  logic                  i_fetch_ready,
   input  logic                  i_decoded_mem,
   input  logic                  i_decoded_ret,
   output logic [WARP_IDX_W-1:0] o_cur_warp,
   output logic [2:0]            o_core_state,
   output logic                  o_issue_valid,
   output logic                  o_lsu_req,
   input  logic                  i_lsu_done_valid,
   input  logic [WARP_IDX_W-1:0] i_lsu_done_warp,
   input  logic [PC_BITS-1:0]    i_next_pc,
   output logic                  o_done
`ifdef WARP_SCHED_PERF_EN
   ,
   output logic [31:0]           o_perf_issued,
   output logic [31:0]           o_perf_stall
`endif
);

   localparam int CNT_W = WARP_IDX_W + 1;

   // THREADS_PER_WARP only travels to the datapath; it is checked here for sanity.
   if (NUM_WARPS < 2 || (NUM_WARPS & (NUM_WARPS - 1)) != 0 || THREADS_PER_WARP < 1) begin : g_param_check
      $error("warp_scheduler: NUM_WARPS must be a power of two >= 2 and THREADS_PER_WARP >= 1");
   end

   core_state_e           r_state;
   logic [PC_BITS-1:0]    r_pc     [NUM_WARPS];
   warp_state_e           r_status [NUM_WARPS];
   logic [WARP_IDX_W-1:0] r_rr_ptr;
   logic [WARP_IDX_W-1:0] r_cur_warp;
   logic                  r_fetch_valid;
   logic [PC_BITS-1:0]    r_fetch_pc;
   logic                  r_issue_valid;
   logic                  r_lsu_req;
   logic                  r_done;

   logic [NUM_WARPS-1:0]  w_ready_mask;
   logic                  w_any_wait;
   logic                  w_grant_valid;
   logic [WARP_IDX_W-1:0] w_grant_idx;
   logic [CNT_W-1:0]      w_active;

   assign w_active = (i_warp_count > CNT_W'(NUM_WARPS)) ? CNT_W'(NUM_WARPS) : i_warp_count;

   always_comb begin
      w_ready_mask = '0;
      w_any_wait   = 1'b0;
      for (int w = 0; w < NUM_WARPS; w++) begin
         w_ready_mask[w] = (r_status[w] == W_READY);
         if (r_status[w] == W_WAIT_MEM) begin
            w_any_wait = 1'b1;
         end
      end
   end

   rr_arbiter #(.N(NUM_WARPS)) u_arb (
      .i_req         (w_ready_mask),
      .i_last        (r_rr_ptr),
      .o_grant_valid (w_grant_valid),
      .o_grant_idx   (w_grant_idx)
   );

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_state       <= S_IDLE;
         for (int w = 0; w < NUM_WARPS; w++) begin
            r_pc[w]     <= '0;
            r_status[w] <= W_IDLE;
         end
         // Pointer parked on the last warp so the first search lands on warp 0.
         r_rr_ptr      <= WARP_IDX_W'(NUM_WARPS - 1);
         r_cur_warp    <= '0;
         r_fetch_valid <= 1'b0;
         r_fetch_pc    <= '0;
         r_issue_valid <= 1'b0;
         r_lsu_req     <= 1'b0;
         r_done        <= 1'b0;
      end else begin
         r_issue_valid <= 1'b0;
         r_lsu_req     <= 1'b0;

         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  for (int w = 0; w < NUM_WARPS; w++) begin
                     r_pc[w]     <= '0;
                     r_status[w] <= (CNT_W'(w) < w_active) ? W_READY : W_DONE;
                  end
                  if (w_active == '0) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= S_SELECT;
                  end
               end
            end

            S_SELECT: begin
               if (w_grant_valid) begin
                  r_cur_warp    <= w_grant_idx;
                  r_rr_ptr      <= w_grant_idx;
                  r_fetch_valid <= 1'b1;
                  r_fetch_pc    <= r_pc[w_grant_idx];
                  r_state       <= S_FETCH;
               end else if (!w_any_wait) begin
                  // Nothing ready and nothing outstanding: every warp has retired.
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end
            end

            S_FETCH: begin
               if (i_fetch_ready) begin
                  r_fetch_valid <= 1'b0;
                  r_state       <= S_DECODE;
               end
            end

            S_DECODE: begin
               if (i_decoded_ret) begin
                  r_status[r_cur_warp] <= W_DONE;
                  r_state              <= S_SELECT;
               end else if (i_decoded_mem) begin
                  // lsu_req shows during the following SELECT cycle, while cur_warp
                  // still names the parked warp.
                  r_status[r_cur_warp] <= W_WAIT_MEM;
                  r_lsu_req            <= 1'b1;
                  r_state              <= S_SELECT;
               end else begin
                  r_issue_valid <= 1'b1;
                  r_state       <= S_EXECUTE;
               end
            end

            S_EXECUTE: begin
               r_state <= S_UPDATE;
            end

            S_UPDATE: begin
               r_pc[r_cur_warp] <= i_next_pc;
               r_state          <= S_SELECT;
            end

            S_DONE: begin
               r_done <= 1'b1;
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase

         // Memory completion runs alongside any phase action. The selected warp is
         // never W_WAIT_MEM, so this never collides with the DECODE/UPDATE writes.
         if (r_state != S_IDLE && i_lsu_done_valid && r_status[i_lsu_done_warp] == W_WAIT_MEM) begin
            r_pc[i_lsu_done_warp]     <= r_pc[i_lsu_done_warp] + PC_BITS'(1);
            r_status[i_lsu_done_warp] <= W_READY;
         end
      end
   end

   assign o_fetch_valid = r_fetch_valid;
   assign o_fetch_pc    = r_fetch_pc;
   assign o_cur_warp    = r_cur_warp;
   assign o_core_state  = r_state;
   assign o_issue_valid = r_issue_valid;
   assign o_lsu_req     = r_lsu_req;
   assign o_done        = r_done;

`ifdef WARP_SCHED_PERF_EN
   logic [31:0] r_perf_issued;
   logic [31:0] r_perf_stall;

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_perf_issued <= '0;
         r_perf_stall  <= '0;
      end else if (r_state != S_DONE) begin
         if ((r_issue_valid || r_lsu_req) && r_perf_issued != '1) begin
            r_perf_issued <= r_perf_issued + 32'd1;
         end
         if (r_state == S_SELECT && !w_grant_valid && w_any_wait && r_perf_stall != '1) begin
            r_perf_stall <= r_perf_stall + 32'd1;
         end
      end
   end

   assign o_perf_issued = r_perf_issued;
   assign o_perf_stall  = r_perf_stall;
`endif

endmodule
